// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared definitions for the convolution layer sequencer.
//   - state_t : sequencer state encoding
//   - NW      : weight words per group (WEIGHT_SIZE*WINDOW_SIZE)
//   - NW_W    : width of the weight word index
// Size macros normally come from CNNConfig.vh.  The fallbacks below keep this
// slice self-contained when that header is not part of the build.
`ifndef WEIGHT_SIZE
`define WEIGHT_SIZE 2
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 3
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif

package cnn_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int NW   = `WEIGHT_SIZE * `WINDOW_SIZE;
    localparam int NW_W = (NW > 1) ? $clog2(NW) : 1;
endpackage

// File: rtl/cnn_weight_bank.sv
// cnn_weight_bank: N x 32-bit weight register array feeding the datapath.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (clears every word)
//   we, idx    : write enable and word index
//   wdata      : word to store at idx
//   weight     : flat view, word k at weight[k*32 +: 32]
module cnn_weight_bank
    import cnn_ctrl_pkg::*;
#(
    parameter int N     = NW,
    parameter int IDX_W = NW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [N*32-1:0]  weight
);
    logic [N-1:0][31:0] mem;

    // Compare-per-word decode keeps indexes >= N (non power-of-two N) harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (we) begin
            for (int i = 0; i < N; i++) begin
                if (idx == IDX_W'(i)) mem[i] <= wdata;
            end
        end
    end

    assign weight = mem;
endmodule

// File: rtl/cnn_conv_ctrl.sv
// cnn_conv_ctrl: layer sequencer for the systolic convolution datapath.
// Accepts one layer command, pulses conf_refresh, then per output-channel
// group loads the full weight bank, streams win_cnt windows and drains.
// Ports:
//   clk, rst                        : clock, async active-low reset
//   cmd_*                           : layer command (valid/ready)
//   w_valid/w_ready/w_data          : weight word stream
//   win_in_valid/win_in_ready/_data : window stream from the window generator
//   weight, kernel_*, act_valid,
//   conf_refresh, window_valid,
//   window, stall                   : datapath programming and stream
//   window_stall, conv_empty,
//   conv_valid                      : datapath status
//   out_ready                       : downstream backpressure (maps to stall)
//   abort                           : synchronous return to IDLE
//   busy, done                      : status, done is a one-cycle pulse
module cnn_conv_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int WEIGHT_SIZE = `WEIGHT_SIZE,
    parameter int WINDOW_SIZE = `WINDOW_SIZE,
    parameter int KERNEL_SIZE = `KERNEL_SIZE,
    parameter int CNT_W       = 16,
    parameter int GRP_W       = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [KERNEL_SIZE-1:0]              cmd_kh,
    input  logic [KERNEL_SIZE-1:0]              cmd_kw,
    input  logic                                cmd_act,
    input  logic [CNT_W-1:0]                    cmd_win_cnt,
    input  logic [GRP_W-1:0]                    cmd_grp_cnt,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic [31:0]                         w_data,
    input  logic                                win_in_valid,
    output logic                                win_in_ready,
    input  logic [WINDOW_SIZE*32-1:0]           win_in_data,
    output logic [WEIGHT_SIZE*WINDOW_SIZE*32-1:0] weight,
    output logic [KERNEL_SIZE-1:0]              kernel_height,
    output logic [KERNEL_SIZE-1:0]              kernel_width,
    output logic                                act_valid,
    output logic                                conf_refresh,
    output logic                                window_valid,
    output logic [WINDOW_SIZE*32-1:0]           window,
    output logic                                stall,
    input  logic                                window_stall,
    input  logic                                conv_empty,
    input  logic [WEIGHT_SIZE-1:0]              conv_valid,
    input  logic                                out_ready,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done
);
    localparam int NWL = WEIGHT_SIZE * WINDOW_SIZE;
    localparam int IW  = (NWL > 1) ? $clog2(NWL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWL - 1);

    state_t            state, nstate;
    logic [CNT_W-1:0]  win_cnt_q, cnt;
    logic [GRP_W-1:0]  grp_left;
    logic [IW-1:0]     widx;
    logic              accept, win_hs, w_hs;

    // The datapath gates stall with its own output valids; nothing to do here.
    logic unused_conv_valid;
    assign unused_conv_valid = |conv_valid;

    assign accept       = cmd_valid & cmd_ready;
    assign w_hs         = w_ready & w_valid;
    assign win_hs       = (state == S_STREAM) & win_in_valid & ~window_stall;
    assign win_in_ready = win_hs;
    assign window_valid = win_hs;
    assign window       = win_in_data;
    assign stall        = ~out_ready;
    assign busy         = (state != S_IDLE);

    always_comb begin
        nstate       = state;
        cmd_ready    = 1'b0;
        conf_refresh = 1'b0;
        w_ready      = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                // Holding off the command during abort keeps the config intact.
                cmd_ready = ~abort;
                if (cmd_valid && !abort)
                    nstate = (cmd_win_cnt == '0 || cmd_grp_cnt == '0) ? S_DONE : S_CONF;
            end
            S_CONF: begin
                conf_refresh = 1'b1;
                nstate       = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && widx == LAST) nstate = S_STREAM;
            end
            S_STREAM: if (win_hs && cnt == CNT_W'(1)) nstate = S_DRAIN;
            S_DRAIN:  if (conv_empty) nstate = (grp_left > GRP_W'(1)) ? S_LOAD_W : S_DONE;
            S_DONE: begin
                done   = ~abort;
                nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
        if (abort) nstate = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            kernel_height <= '0;
            kernel_width  <= '0;
            act_valid     <= 1'b0;
            win_cnt_q     <= '0;
            cnt           <= '0;
            grp_left      <= '0;
            widx          <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                kernel_height <= cmd_kh;
                kernel_width  <= cmd_kw;
                act_valid     <= cmd_act;
                win_cnt_q     <= cmd_win_cnt;
            end
            if (abort) begin
                cnt      <= '0;
                grp_left <= '0;
                widx     <= '0;
            end else begin
                case (state)
                    S_IDLE:   if (accept) grp_left <= cmd_grp_cnt;
                    S_CONF:   widx <= '0;
                    S_LOAD_W: if (w_valid) begin
                        widx <= (widx == LAST) ? '0 : widx + 1'b1;
                        if (widx == LAST) cnt <= win_cnt_q;
                    end
                    S_STREAM: if (win_hs) cnt <= cnt - 1'b1;
                    S_DRAIN:  if (conv_empty) grp_left <= grp_left - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Writes go through even on an abort cycle so the handshake completes.
    cnn_weight_bank #(.N(NWL), .IDX_W(IW)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (w_hs),
        .idx    (widx),
        .wdata  (w_data),
        .weight (weight)
    );
endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// Scoreboard bench for cnn_conv_ctrl: the driver pushes the expected event
// sequence (CONF, weight words, windows, DONE) for each command; a negedge
// monitor pops and compares whenever the DUT shows the matching handshake.
`ifndef WEIGHT_SIZE
`define WEIGHT_SIZE 2
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 3
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif

module tb_cnn_conv_ctrl;
    localparam int WS = `WEIGHT_SIZE;
    localparam int WN = `WINDOW_SIZE;
    localparam int KS = `KERNEL_SIZE;
    localparam int NW = WS * WN;
    localparam int WB = NW * 32;
    localparam int XB = WN * 32;
    localparam int CW = 16;
    localparam int GW = 8;
    localparam int BOUND = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [KS-1:0] cmd_kh = '0, cmd_kw = '0;
    logic cmd_act = 1'b0;
    logic [CW-1:0] cmd_win_cnt = '0;
    logic [GW-1:0] cmd_grp_cnt = '0;
    logic w_valid = 1'b0, w_ready;
    logic [31:0] w_data = '0;
    logic win_in_valid = 1'b0, win_in_ready;
    logic [XB-1:0] win_in_data = '0;
    logic [WB-1:0] weight;
    logic [KS-1:0] kernel_height, kernel_width;
    logic act_valid, conf_refresh, window_valid;
    logic [XB-1:0] window;
    logic stall, busy, done;
    logic window_stall = 1'b0, conv_empty = 1'b0, out_ready = 1'b1, abort = 1'b0;
    logic [WS-1:0] conv_valid = '0;

    always #5 clk = ~clk;

    cnn_conv_ctrl #(.WEIGHT_SIZE(WS), .WINDOW_SIZE(WN), .KERNEL_SIZE(KS),
                    .CNT_W(CW), .GRP_W(GW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kh(cmd_kh), .cmd_kw(cmd_kw),
        .cmd_act(cmd_act), .cmd_win_cnt(cmd_win_cnt), .cmd_grp_cnt(cmd_grp_cnt),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .win_in_valid(win_in_valid), .win_in_ready(win_in_ready), .win_in_data(win_in_data),
        .weight(weight), .kernel_height(kernel_height), .kernel_width(kernel_width),
        .act_valid(act_valid), .conf_refresh(conf_refresh),
        .window_valid(window_valid), .window(window), .stall(stall),
        .window_stall(window_stall), .conv_empty(conv_empty), .conv_valid(conv_valid),
        .out_ready(out_ready), .abort(abort), .busy(busy), .done(done)
    );

    typedef enum int {K_CONF, K_W, K_WIN, K_DONE} kind_t;
    typedef struct {
        kind_t         kind;
        int            idx;
        logic [XB-1:0] data;
    } ev_t;

    ev_t q[$];
    logic [31:0] mw [NW];
    logic [KS-1:0] m_kh = '0, m_kw = '0;
    logic m_act = 1'b0;
    int cyc = 0, checks = 0, errors = 0;
    int exp_conf_cyc = -1, exp_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chki(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chkv(string name, logic [WB-1:0] got, logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [WB-1:0] model_weight();
        logic [WB-1:0] f;
        for (int k = 0; k < NW; k++) f[k*32 +: 32] = mw[k];
        return f;
    endfunction

    task automatic take(kind_t k, output ev_t e, output bit ok);
        checks++;
        e.kind = k; e.idx = 0; e.data = '0; ok = 0;
        if (q.size() == 0 || q[0].kind != k) begin
            errors++;
            $display("FAIL event: got kind %0d expected kind %0d (pending %0d, cycle %0d)",
                     int'(k), (q.size() != 0) ? int'(q[0].kind) : -1, q.size(), cyc);
        end else begin
            e = q.pop_front();
            ok = 1;
        end
    endtask

    // Monitor: every negedge while out of reset.
    ev_t me;
    bit  mok;
    always @(negedge clk) begin
        if (rst) begin
            chki("stall", 32'(stall), 32'(!out_ready));
            chki("window_valid_eq_ready", 32'(window_valid), 32'(win_in_ready));
            if (window_stall) chki("window_stall_blocks", 32'(win_in_ready), 32'd0);
            if (!abort) chki("busy_vs_cmd_ready", 32'(busy), 32'(!cmd_ready));
            chkv("weight", weight, model_weight());
            chki("kernel_height", 32'(kernel_height), 32'(m_kh));
            chki("kernel_width", 32'(kernel_width), 32'(m_kw));
            chki("act_valid", 32'(act_valid), 32'(m_act));
            if (conf_refresh) begin
                take(K_CONF, me, mok);
                chki("conf_cycle", 32'(cyc), 32'(exp_conf_cyc));
            end
            if (w_ready && w_valid) begin
                take(K_W, me, mok);
                if (mok) mw[me.idx] = me.data[31:0];
            end
            if (window_valid) begin
                take(K_WIN, me, mok);
                if (mok) chkv("window", WB'(window), WB'(me.data));
            end
            if (done) begin
                take(K_DONE, me, mok);
                chki("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            end
        end
    end

    task automatic idle_inputs();
        cmd_valid = 0; w_valid = 0; win_in_valid = 0; window_stall = 0;
        conv_empty = 0; out_ready = 1; abort = 0;
    endtask

    task automatic reset_model();
        q.delete();
        for (int k = 0; k < NW; k++) mw[k] = '0;
        m_kh = '0; m_kw = '0; m_act = 1'b0;
    endtask

    task automatic check_reset(string tag);
        chki({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chki({tag, "_busy"}, 32'(busy), 32'd0);
        chki({tag, "_done"}, 32'(done), 32'd0);
        chki({tag, "_conf_refresh"}, 32'(conf_refresh), 32'd0);
        chki({tag, "_w_ready"}, 32'(w_ready), 32'd0);
        chki({tag, "_win_in_ready"}, 32'(win_in_ready), 32'd0);
        chki({tag, "_window_valid"}, 32'(window_valid), 32'd0);
        chkv({tag, "_weight"}, weight, '0);
        chki({tag, "_kernel"}, 32'({kernel_height, kernel_width, act_valid}), 32'd0);
    endtask

    task automatic timeout(string what);
        checks++; errors++;
        $display("FAIL timeout %s: no handshake within %0d cycles", what, BOUND);
        rst = 0; #1;
        reset_model(); idle_inputs();
        #10 rst = 1;
    endtask

    // One command. stall_at: window index where a 5-cycle backpressure block
    // starts; abort_at: abort together with that weight word (1-based);
    // rst_at: async reset after that many windows. Negative disables.
    task automatic run_cmd(input logic [KS-1:0] kh, input logic [KS-1:0] kw, input logic act,
                           input int win, input int grp, input bit cont,
                           input int stall_at, input int abort_at, input int rst_at);
        logic [31:0]   wq[$];
        logic [XB-1:0] xq[$];
        logic [XB-1:0] x;
        logic [31:0]   w;
        ev_t e;
        int acc, k, j, n, sc, r, d;
        bit empty_run;
        empty_run = (win == 0 || grp == 0);
        e.idx = 0; e.data = '0;
        if (!empty_run) begin
            e.kind = K_CONF; q.push_back(e);
            for (int g = 0; g < grp; g++) begin
                for (int i = 0; i < NW; i++) begin
                    w = $urandom;
                    wq.push_back(w);
                    if (abort_at < 0 || (g == 0 && i < abort_at)) begin
                        e.kind = K_W; e.idx = i; e.data = XB'(w); q.push_back(e);
                    end
                end
                for (int i = 0; i < win; i++) begin
                    for (int b = 0; b < WN; b++) x[b*32 +: 32] = $urandom;
                    xq.push_back(x);
                    if (abort_at < 0 && (rst_at < 0 || (g == 0 && i < rst_at))) begin
                        e.kind = K_WIN; e.idx = i; e.data = x; q.push_back(e);
                    end
                end
            end
        end
        if (abort_at < 0 && rst_at < 0) begin
            e.kind = K_DONE; e.idx = 0; e.data = '0; q.push_back(e);
        end

        @(posedge clk); #1;
        cmd_valid = 1; cmd_kh = kh; cmd_kw = kw; cmd_act = act;
        cmd_win_cnt = CW'(win); cmd_grp_cnt = GW'(grp);
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > BOUND) begin timeout("cmd_accept"); return; end
        end
        acc = cyc; exp_conf_cyc = acc + 1; exp_done_cyc = acc + 1;
        @(posedge clk); #1;
        cmd_valid = 0; m_kh = kh; m_kw = kw; m_act = act;

        if (empty_run) begin
            // Offer both streams: any acceptance shows up as an unexpected event.
            w_valid = 1; win_in_valid = 1;
            repeat (4) @(posedge clk);
            #1 w_valid = 0; win_in_valid = 0;
            chki("queue_drained", 32'(q.size()), 32'd0);
            return;
        end

        for (int g = 0; g < grp; g++) begin
            k = 0; n = 0;
            while (k < NW) begin
                w_valid = cont || ($urandom_range(0, 3) != 0);
                w_data = wq[g*NW + k];
                if (abort_at >= 0 && k == abort_at - 1) begin w_valid = 1; abort = 1; end
                @(negedge clk);
                if (w_valid && w_ready) begin
                    if (cont && g == 0 && k == 0) chki("first_w_cycle", 32'(cyc), 32'(acc + 2));
                    k++;
                end
                @(posedge clk); #1;
                if (abort) begin
                    abort = 0; w_valid = 0;
                    @(negedge clk);
                    chki("abort_busy", 32'(busy), 32'd0);
                    chki("abort_cmd_ready", 32'(cmd_ready), 32'd1);
                    repeat (4) @(negedge clk);
                    chki("abort_queue", 32'(q.size()), 32'd0);
                    return;
                end
                n++;
                if (n > BOUND) begin timeout("weights"); return; end
            end
            w_valid = 0;

            j = 0; n = 0; sc = 0;
            while (j < win) begin
                if (stall_at >= 0 && g == 0 && j == stall_at && sc < 5) begin
                    out_ready = 0; window_stall = 1; win_in_valid = 1; sc++;
                end else begin
                    out_ready = ($urandom_range(0, 7) != 0);
                    window_stall = !cont && ($urandom_range(0, 4) == 0);
                    win_in_valid = cont || ($urandom_range(0, 3) != 0);
                end
                win_in_data = xq[g*win + j];
                @(negedge clk);
                if (win_in_valid && win_in_ready) begin
                    if (cont && g == 0 && j == 0)
                        chki("first_win_cycle", 32'(cyc), 32'(acc + 2 + NW));
                    j++;
                end
                @(posedge clk);
                if (rst_at >= 0 && j == rst_at) begin
                    #3 rst = 0;
                    #1 check_reset("reset_mid_stream");
                    reset_model(); idle_inputs();
                    #13 rst = 1;
                    @(negedge clk);
                    chki("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
                    chki("post_reset_busy", 32'(busy), 32'd0);
                    return;
                end
                #1;
                n++;
                if (n > BOUND) begin timeout("windows"); return; end
            end

            // Keep offering junk during drain: any extra acceptance is caught.
            win_in_valid = 1; window_stall = 0; out_ready = 1; win_in_data = '1;
            r = $urandom_range(0, 2);
            repeat (r) begin @(posedge clk); #1; end
            conv_empty = 1; d = cyc;
            if (g == grp - 1) exp_done_cyc = d + 1;
            @(posedge clk); #1;
            conv_empty = 0; win_in_valid = 0;
        end
        repeat (3) @(posedge clk);
        #1 chki("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        #2 rst = 0;
        #1 check_reset("reset");
        #20 rst = 1;
        // 3x3 kernel, ReLU, one group of four windows, continuous streams.
        run_cmd(KS'(2), KS'(2), 1'b1, 4, 1, 1'b1, -1, -1, -1);
        // Empty commands finish without configuring or loading.
        run_cmd(KS'(5), KS'(1), 1'b0, 0, 1, 1'b0, -1, -1, -1);
        run_cmd(KS'(1), KS'(6), 1'b1, 5, 0, 1'b0, -1, -1, -1);
        // Two groups of three windows with random gaps.
        run_cmd(KS'(4), KS'(4), 1'b0, 3, 2, 1'b0, -1, -1, -1);
        // Five cycles of downstream backpressure mid-stream.
        run_cmd(KS'(3), KS'(2), 1'b1, 6, 1, 1'b0, 2, -1, -1);
        // Abort with the third weight word, then a full reload.
        run_cmd(KS'(6), KS'(3), 1'b1, 4, 1, 1'b0, -1, 3, -1);
        run_cmd(KS'(2), KS'(5), 1'b0, 2, 1, 1'b0, -1, -1, -1);
        for (int i = 0; i < 8; i++)
            run_cmd(KS'($urandom), KS'($urandom), 1'($urandom), $urandom_range(1, 5),
                    $urandom_range(1, 3), 1'b0, -1, -1, -1);
        // Asynchronous reset in the middle of streaming, then a clean command.
        run_cmd(KS'(7), KS'(7), 1'b1, 5, 1, 1'b0, -1, -1, 2);
        run_cmd(KS'(2), KS'(2), 1'b1, 2, 1, 1'b1, -1, -1, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_conv_ctrl.md
# cnn_conv_ctrl

Layer sequencer for the systolic convolution datapath (`CNNConv`). It accepts one layer command and programs the kernel configuration, pulsing `conf_refresh`. For each output-channel group it then loads the full weight bank word by word, streams a fixed number of input windows into the datapath, and drains the pipeline before reloading weights. It sits between the window generator / weight fetcher and `CNNConv`, and maps downstream backpressure onto the datapath `stall`.

## Interface
- `WEIGHT_SIZE`, default `` `WEIGHT_SIZE ``: output channels per group (datapath columns).
- `WINDOW_SIZE`, default `` `WINDOW_SIZE ``: window taps (datapath rows).
- `KERNEL_SIZE`, default `` `KERNEL_SIZE ``: width of kernel_height/kernel_width codes.
- `CNT_W`, default 16: width of the window count.
- `GRP_W`, default 8: width of the group count.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` / `cmd_ready`, in/out 1: command handshake.
- `cmd_kh`, `cmd_kw` in KERNEL_SIZE: kernel height/width codes.
- `cmd_act` in 1: apply ReLU.
- `cmd_win_cnt` in CNT_W: windows per group.
- `cmd_grp_cnt` in GRP_W: number of weight groups.
- `w_valid` / `w_ready`, in/out 1: weight word stream handshake.
- `w_data` in 32: weight word.
- `win_in_valid` / `win_in_ready`, in/out 1: window stream handshake.
- `win_in_data` in WINDOW_SIZE*32: window.
- `weight` out WEIGHT_SIZE*WINDOW_SIZE*32: to the datapath.
- `kernel_height`, `kernel_width` out KERNEL_SIZE; `act_valid` out 1; `conf_refresh` out 1.
- `window_valid` out 1; `window` out WINDOW_SIZE*32.
- `stall` out 1; `window_stall` in 1; `conv_empty` in 1; `conv_valid` in WEIGHT_SIZE.
- `out_ready` in 1: downstream accepts results.
- `abort` in 1: synchronous return to IDLE.
- `busy` out 1; `done` out 1 (one-cycle pulse).

## Operation
- States: IDLE, CONF, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - `cmd_ready=1`.
  - On accept, register kh, kw, act, win_cnt, grp_cnt.
  - If win_cnt==0 or grp_cnt==0, go to DONE with no `conf_refresh` and no weight load. Otherwise go to CONF.
- CONF: `conf_refresh=1` for exactly one cycle, with the new kernel registers already driven. Then go to LOAD_W.
- LOAD_W:
  - `w_ready=1`; word index k runs 0..WEIGHT_SIZE*WINDOW_SIZE-1.
  - Accepted word k is written to `weight[k*32+:32]`.
  - After the last word is accepted, go to STREAM with the window counter reset to win_cnt.
- STREAM:
  - `win_in_ready = window_valid = win_in_valid & ~window_stall`; `window = win_in_data` (combinational pass-through).
  - Each handshake decrements the counter. The handshake that takes it to 0 moves the block to DRAIN.
- DRAIN:
  - Stay at least one cycle.
  - Exit when `conv_empty==1`: to LOAD_W if groups remain (group counter decremented), else to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- `stall = ~out_ready` in all states. The datapath itself qualifies stall with its own output valids.
- `weight`, `kernel_height`, `kernel_width` and `act_valid` change only in IDLE accept / LOAD_W. They are stable from STREAM through DRAIN.
- `abort`:
  - From any state, go to IDLE next cycle. Counters clear; `done` is not pulsed.
  - `weight` and the config registers hold their values.
  - An abort in the cycle of a `w`/`win_in` handshake still completes that handshake.
- `busy = (state != IDLE)`.

## Timing
- Reset values:
  - state IDLE, so `cmd_ready=1` and `busy=0`.
  - `done=0`, `conf_refresh=0`, `w_ready=0`, `win_in_ready=0`, `window_valid=0`.
  - `weight=0`, kernel codes 0, `act_valid=0`.
- Sequence from a command accept at cycle 0:
  - CONF at cycle 1.
  - `w_ready` high from cycle 2.
  - With continuous `w_valid`, STREAM begins at cycle 2+WEIGHT_SIZE*WINDOW_SIZE.
- The first `win_in_ready` occurs in the first STREAM cycle.
- `done` rises one cycle after DRAIN sees `conv_empty`.
- `window_stall` high forces `win_in_ready=0` in the same cycle, with no lost or duplicated windows.
- Gaps in `win_in_valid` insert bubbles (`window_valid=0`) that the datapath shifts as zeros. They are not counted.

## Structure
- Shared package `cnn_ctrl_pkg`: state encoding, and localparam NW = WEIGHT_SIZE*WINDOW_SIZE with its index width. Size macros come from CNNConfig.vh.
- Sub-module `cnn_weight_bank`: NW×32 register array with write-enable and index. It is asynchronously reset to 0 and presents the flat `weight` vector.

## Test plan
- 3×3 kernel (kh=kw=0b010), act=1, grp=1, win=4, continuous streams:
  - one `conf_refresh` at cycle 1;
  - NW weight handshakes, with `weight[k*32+:32]` equal to the k-th word;
  - exactly 4 window handshakes;
  - `done` one cycle after `conv_empty`.
- win_cnt=0:
  - accept -> `done` at cycle 1;
  - no `conf_refresh`, `w_ready` never high.
- grp=2, win=3:
  - two LOAD_W phases;
  - second-group weights never change while `conv_empty=0`;
  - 6 windows total.
- `out_ready=0` for 5 cycles mid-STREAM with the bench driving `window_stall=1`: `win_in_ready=0` throughout, and the window count is unaffected.
- `abort` in LOAD_W after 3 words:
  - IDLE next cycle, no `done`;
  - the next command reloads all NW words from index 0.
- Async reset asserted mid-STREAM: all outputs at their reset values immediately, and `cmd_ready=1` after release.
